// File: rtl/mod_sseg_hex_if.sv
// Data-bus port bundle for the hex front end: the master (CPU) drives requests,
// the slave (peripheral) returns readback data.
interface mod_sseg_hex_if;
    logic        ie;
    logic        de;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic        drw;
    logic [31:0] din;
    logic [31:0] iout;
    logic [31:0] dout;

    modport master (
        output ie, de, iaddr, daddr, drw, din,
        input  iout, dout
    );

    modport slave (
        input  ie, de, iaddr, daddr, drw, din,
        output iout, dout
    );
endinterface

// File: rtl/mod_sseg_hex.sv
// Hex front end for the seven-segment peripheral: encodes a 16-bit value into
// four active-low segment bytes and pushes the word downstream on a write strobe.
//
// state | meaning
// IDLE  | waiting for DIRTY; snapshots VALUE, CTRL and blink phase on exit
// ENC   | encodes one digit per cycle, digit 3 first
// PUSH  | one-cycle downstream write strobe with sseg_din valid
module mod_sseg_hex #(
    parameter int CLOCK_FREQ = 25000000,
    parameter int BLINK_HZ   = 2
) (
    input  logic        clk,
    input  logic        rst,
    mod_sseg_hex_if.slave bus,
    output logic        sseg_de,
    output logic        sseg_drw,
    output logic [31:0] sseg_din
);

    localparam int HALF = CLOCK_FREQ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENC,
        S_PUSH
    } state_t;

    state_t          state_q;
    state_t          state_nxt;

    logic [15:0]     value_q;
    logic [7:0]      ctrl_q;
    logic            dirty_q;
    logic [CW-1:0]   blink_cnt;
    logic            phase_q;

    logic [15:0]     snap_value;
    logic [7:0]      snap_ctrl;
    logic            snap_phase;
    logic [1:0]      idx_q;
    logic            zrun_q;
    logic [31:0]     work_q;

    logic            wr_en;
    logic            toggle;
    logic            leave_idle;
    logic [3:0]      nib;
    logic [3:0]      dp_mask;
    logic            blank_dig;
    logic            blank_all;
    logic [7:0]      seg_byte;
    logic            unused_bits;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_seg = 8'hC0;
            4'h1:    hex_seg = 8'hF9;
            4'h2:    hex_seg = 8'hA4;
            4'h3:    hex_seg = 8'hB0;
            4'h4:    hex_seg = 8'h99;
            4'h5:    hex_seg = 8'h92;
            4'h6:    hex_seg = 8'h82;
            4'h7:    hex_seg = 8'hF8;
            4'h8:    hex_seg = 8'h80;
            4'h9:    hex_seg = 8'h90;
            4'hA:    hex_seg = 8'h88;
            4'hB:    hex_seg = 8'h83;
            4'hC:    hex_seg = 8'hC6;
            4'hD:    hex_seg = 8'hA1;
            4'hE:    hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
    endfunction

    assign wr_en      = bus.de & bus.drw;
    assign toggle     = (blink_cnt == CW'(HALF - 1));
    assign leave_idle = (state_q == S_IDLE) && dirty_q;
    assign unused_bits = ^{bus.ie, bus.iaddr, bus.daddr[31:3], bus.daddr[1:0], bus.din[31:16]};

    assign bus.iout = 32'h0;
    assign bus.dout = bus.daddr[2] ? {23'h0, (state_q != S_IDLE), ctrl_q}
                                   : {16'h0, value_q};

    always_ff @(negedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        sseg_de   = 1'b0;
        sseg_drw  = 1'b0;
        case (state_q)
            S_IDLE: if (dirty_q) state_nxt = S_ENC;
            S_ENC:  if (idx_q == 2'd0) state_nxt = S_PUSH;
            S_PUSH: begin
                sseg_de   = 1'b1;
                sseg_drw  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Current digit; zrun_q tracks "all higher digits were zero" for blanking.
    always_comb begin
        nib       = snap_value[{idx_q, 2'b00} +: 4];
        dp_mask   = snap_ctrl[7:4];
        blank_dig = snap_ctrl[1] && zrun_q && (nib == 4'h0) && (idx_q != 2'd0);
        blank_all = !snap_ctrl[0] || (snap_ctrl[2] && !snap_phase);
        seg_byte  = blank_dig ? 8'hFF : hex_seg(nib);
        if (dp_mask[idx_q]) seg_byte[7] = 1'b0;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            value_q    <= 16'h0;
            ctrl_q     <= 8'h0;
            dirty_q    <= 1'b1;
            blink_cnt  <= '0;
            phase_q    <= 1'b1;
            snap_value <= 16'h0;
            snap_ctrl  <= 8'h0;
            snap_phase <= 1'b1;
            idx_q      <= 2'd3;
            zrun_q     <= 1'b1;
            work_q     <= 32'hFFFF_FFFF;
            sseg_din   <= 32'hFFFF_FFFF;
        end else begin
            if (wr_en && !bus.daddr[2]) value_q <= bus.din[15:0];
            if (wr_en &&  bus.daddr[2]) ctrl_q  <= bus.din[7:0];

            if (toggle) begin
                blink_cnt <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blink_cnt <= blink_cnt + CW'(1);
            end

            // Setting wins over the clear so a write on the exit edge is not lost.
            if (wr_en || (toggle && ctrl_q[0] && ctrl_q[2])) dirty_q <= 1'b1;
            else if (leave_idle)                              dirty_q <= 1'b0;

            if (leave_idle) begin
                snap_value <= value_q;
                snap_ctrl  <= ctrl_q;
                snap_phase <= phase_q;
                idx_q      <= 2'd3;
                zrun_q     <= 1'b1;
            end

            if (state_q == S_ENC) begin
                work_q[{idx_q, 3'b000} +: 8] <= seg_byte;
                zrun_q <= zrun_q && (nib == 4'h0);
                idx_q  <= idx_q - 2'd1;
                if (idx_q == 2'd0)
                    sseg_din <= blank_all ? 32'hFFFF_FFFF : {work_q[31:8], seg_byte};
            end
        end
    end

endmodule

// File: tb/tb_mod_sseg_hex.sv
// Directed bench for mod_sseg_hex: expected pushes (word + strobe cycle) are queued
// by the stimulus and checked by an independent monitor on each strobe.
module tb_mod_sseg_hex;

    logic        clk = 1'b1;
    logic        rst;
    logic        sseg_de;
    logic        sseg_drw;
    logic [31:0] sseg_din;

    mod_sseg_hex_if bus ();

    mod_sseg_hex #(.CLOCK_FREQ(40), .BLINK_HZ(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sseg_de  (sseg_de),
        .sseg_drw (sseg_drw),
        .sseg_din (sseg_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          at;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_de = 1'b0;

    always @(negedge clk) cyc = cyc + 1;

    // Monitor: each strobe must match the oldest queued word at its expected cycle.
    always @(posedge clk) begin
        exp_t e;
        if (sseg_de) begin
            total++;
            if (prev_de) begin
                bad++;
                $display("FAIL de_width: strobe high on consecutive cycles at cyc %0d", cyc);
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL extra_push: got %h at cyc %0d, required no push", sseg_din, cyc);
            end else begin
                e = q.pop_front();
                if (sseg_din !== e.val || cyc != e.at || sseg_drw !== 1'b1)
                begin
                    bad++;
                    $display("FAIL push: got %h at cyc %0d drw=%b, required %h at cyc %0d drw=1",
                             sseg_din, cyc, sseg_drw, e.val, e.at);
                end
            end
        end
        prev_de = sseg_de;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    task automatic expect_push(input logic [31:0] v, input int at);
        q.push_back('{val: v, at: at});
    endtask

    // Write lands on negedge n; the strobe is then sampled at the posedge where cyc == n+5.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int n);
        @(posedge clk);
        bus.daddr = a;
        bus.din   = d;
        bus.de    = 1'b1;
        bus.drw   = 1'b1;
        n = cyc + 1;
        @(posedge clk);
        bus.de    = 1'b0;
        bus.drw   = 1'b0;
    endtask

    task automatic wr_exp(input logic [31:0] a, input logic [31:0] d, input logic [31:0] v);
        int n;
        wr(a, d, n);
        expect_push(v, n + 5);
        drain();
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] want);
        @(posedge clk);
        bus.daddr = a;
        #1;
        chk(nm, bus.dout, want);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending pushes, required 0", q.size());
            q.delete();
        end
    endtask

    function automatic logic [31:0] ph(input int k);
        ph = (k % 2 == 0) ? 32'h8080_8080 : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int n, r, k, t, tt;
        rst = 1'b1;
        bus.ie = 1'b0; bus.de = 1'b0; bus.drw = 1'b0;
        bus.iaddr = 32'h0; bus.daddr = 32'h0; bus.din = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_de",   {31'h0, sseg_de},  32'h0);
        chk("rst_drw",  {31'h0, sseg_drw}, 32'h0);
        chk("rst_din",  sseg_din,          32'hFFFF_FFFF);
        chk("rst_iout", bus.iout,          32'h0);
        chk("rst_val",  bus.dout,          32'h0);
        bus.daddr = 32'h4;
        #1;
        chk("rst_ctrl", bus.dout,          32'h0);

        @(posedge clk);
        r = cyc;
        rst = 1'b0;
        expect_push(32'hFFFF_FFFF, r + 5);
        drain();
        rd("busy_idle", 32'h4, 32'h0);

        wr_exp(32'h0, 32'hABCD_12AF, 32'hFFFF_FFFF);
        rd("value_16b", 32'h0, 32'h0000_12AF);
        wr_exp(32'h4, 32'h01, 32'hF9A4_888E);
        rd("ctrl_rb", 32'h4, 32'h0000_0001);

        wr_exp(32'h0, 32'h0005, 32'hC0C0_C092);
        wr_exp(32'h4, 32'h03,   32'hFFFF_FF92);
        wr_exp(32'h0, 32'h0000, 32'hFFFF_FFC0);
        wr_exp(32'h4, 32'h13,   32'hFFFF_FF40);
        wr_exp(32'h4, 32'hF3,   32'h7F7F_7F40);
        wr_exp(32'h0, 32'h0105, 32'h7F79_4012);
        wr_exp(32'h4, 32'h03,   32'hFFF9_C092);
        wr_exp(32'h4, 32'h01,   32'hC0F9_C092);

        // Second write lands during ENC of the first: exactly one follow-up push.
        wr(32'h0, 32'h1111, n);
        expect_push(32'hF9F9_F9F9, n + 5);
        expect_push(32'hA4A4_A4A4, n + 11);
        wr(32'h0, 32'h2222, t);
        chk("wr_gap", t - n, 32'd2);
        drain();
        repeat (30) @(posedge clk);
        chk("no_third", q.size(), 32'h0);

        wr(32'h0, 32'h4444, n);
        repeat (2) @(posedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_de",  {31'h0, sseg_de}, 32'h0);
        chk("mid_rst_din", sseg_din,         32'hFFFF_FFFF);
        bus.daddr = 32'h4;
        #1;
        chk("mid_rst_ctrl", bus.dout,        32'h0);
        repeat (2) @(posedge clk);
        r = cyc;
        rst = 1'b0;
        expect_push(32'hFFFF_FFFF, r + 5);
        drain();

        // Blink: toggles at negedges r+10k; align the CTRL write to land just after one.
        wr_exp(32'h0, 32'h8888, 32'hFFFF_FFFF);
        t = 0;
        while (((cyc - r) % 10) != 9 && t < 40) begin
            @(posedge clk);
            t++;
        end
        wr(32'h4, 32'h05, n);
        k = (n - r) / 10;
        expect_push(ph(k), n + 5);
        for (int j = 1; j <= 4; j++) expect_push(ph(k + j), r + 10 * (k + j) + 5);
        tt = r + 10 * (k + 4);
        t = 0;
        while (cyc < tt + 4 && t < 100) begin
            @(posedge clk);
            t++;
        end
        wr(32'h4, 32'h00, n);
        expect_push(32'hFFFF_FFFF, n + 5);
        drain();
        repeat (25) @(posedge clk);
        chk("blink_stop", q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mod_sseg_hex.md
# mod_sseg_hex

Memory-mapped hex front end for the seven-segment peripheral. Software writes a 16-bit value and a control word over the data bus. A small FSM encodes the four nibbles into active-low segment bytes, applying leading-zero blanking, decimal points and blink. It then pushes the 32-bit pattern word into the downstream seven-segment register through a one-cycle bus-style write strobe.

## Interface
- CLOCK_FREQ, 25000000: clk frequency in Hz.
- BLINK_HZ, 2: blink rate in Hz. Phase toggles every CLOCK_FREQ/(2*BLINK_HZ) cycles.
- clk  in  1  system clock; all state updates on negedge clk, matching the data bus.
- rst  in  1  reset, asynchronous, active-high.
- ie, de  in  1 each  instruction/data enables from the bus.
- iaddr, daddr  in  32 each  bus addresses; only daddr[2] is decoded.
- drw  in  1  data write request.
- din  in  32  write data.
- iout  out  32  constant 0.
- dout  out  32  register readback.
- sseg_de  out  1  downstream write enable.
- sseg_drw  out  1  downstream write request.
- sseg_din  out  32  pattern word: [31:24] digit 3 (leftmost), [7:0] digit 0.

## Operation
- Registers, written when de && drw at negedge clk:
  - daddr[2]=0: VALUE = din[15:0].
  - daddr[2]=1: CTRL = din[7:0]. Bit0 EN, bit1 LZB (leading-zero blank), bit2 BLINK, bits[7:4] DP mask (bit4 = digit 0).
- Readback:
  - daddr[2]=0: dout = {16'h0, VALUE}.
  - daddr[2]=1: dout = {23'h0, BUSY, CTRL}, where BUSY = FSM not in IDLE.
- Segment byte: bit7 = dp, bits[6:0] = g..a, active-low.
- Nibble codes 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Blank digit = 0xFF. A set DP bit clears bit7 of that digit, including on blanked digits.
- LZB: digits are scanned 3 down to 1. Each is blanked while it and all higher digits are 0. Digit 0 is never blanked.
- Pushed word is 0xFFFFFFFF when EN=0, or when BLINK=1 and the blink phase is off.
- DIRTY flag:
  - Set by any register write.
  - Set by a blink phase toggle, only while EN=1 and BLINK=1.
  - Cleared when the FSM leaves IDLE.
- FSM states:
  - IDLE: if DIRTY, snapshot VALUE, CTRL and blink phase, then go to ENC.
  - ENC: four cycles, encoding one digit per cycle, digit 3 first (needed for LZB tracking). Then go to PUSH.
  - PUSH: sseg_de=sseg_drw=1 for one cycle with sseg_din valid. Then go to IDLE.
- A write during ENC or PUSH does not alter the in-flight word. It sets DIRTY, so a second push follows immediately after returning to IDLE.
- The blink counter runs free regardless of EN. It wraps to 0 at the terminal count.

## Timing
- Reset values:
  - VALUE=0, CTRL=0, FSM=IDLE, DIRTY=1.
  - Blink counter=0, phase=on.
  - sseg_de=0, sseg_drw=0, sseg_din=0xFFFFFFFF, iout=0.
- The first push after reset therefore blanks the display.
- Latency, for a write at negedge N:
  - N+1: IDLE to ENC.
  - N+1 to N+4: ENC.
  - PUSH strobe high from negedge N+5 to negedge N+6.
  - Downstream captures the word at negedge N+6.
- sseg_din holds its last pushed value between pushes.
- A reset asserted mid-ENC or mid-PUSH immediately returns all state and outputs to reset values, and the strobe drops at once. The pending blank push then occurs after reset release.
- Write and blink toggle on the same edge set DIRTY once, producing a single push.
- Only 16 bits of VALUE are stored. din[31:16] is ignored.

## Test plan
- Reset, then release -> one push of 0xFFFFFFFF at the 6th negedge after release; BUSY reads 0 afterwards.
- Write VALUE=0x12AF, CTRL=0x01 -> push 0xF9A4888E; sseg_de high exactly one cycle.
- CTRL=0x03 with VALUE=0x0005 -> 0xFFFFFF92. With VALUE=0x0000 -> 0xFFFFFFC0. CTRL=0x13 with VALUE=0x0000 -> 0xFFFFFF40.
- CTRL=0x05, VALUE=0x8888, CLOCK_FREQ=40, BLINK_HZ=2 -> pushes alternate 0xFFFFFFFF and 0x80808080 every 10 cycles.
- Write VALUE=0x1111 then VALUE=0x2222 two cycles later (CTRL=0x01) -> first push 0xF9F9F9F9, then 0xA4A4A4A4; no third push.
- Assert rst during ENC -> strobe never rises, outputs at reset values; after release, a push of 0xFFFFFFFF.
